// File: rtl/mips_boot_loader.sv
// mips_boot_loader
//   Boot loader between an external word stream and the MIPS core's instruction
//   and data memories. After reset (or a reload pulse) it zero-fills both memories,
//   then accepts framed segments (header, base address, data words) and holds the
//   core in reset until a GO header arrives.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   reload      one-cycle pulse, restarts boot from the clear phase
//   s_data      stream word
//   s_valid     stream word valid
//   s_ready     block accepts a word (combinational)
//   imem_we     instruction memory write strobe (registered)
//   imem_addr   instruction memory word address (registered)
//   imem_wdata  instruction memory write data (registered)
//   dmem_we     data memory write strobe (registered)
//   dmem_addr   data memory word address (registered)
//   dmem_wdata  data memory write data (registered)
//   core_rst    active-high reset to the core (registered)
//   done        boot complete, core running (registered)
//   err         sticky framing/range error (registered)
//
// Header word: [31:30] op (00 IMEM, 01 DMEM, 10 GO, 11 illegal), [15:0] word count.

module mips_boot_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMEM_DEPTH = 512,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned IMEM_AW    = $clog2(IMEM_DEPTH),
  parameter int unsigned DMEM_AW    = $clog2(DMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reload,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  imem_we,
  output logic [IMEM_AW-1:0]    imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  dmem_we,
  output logic [DMEM_AW-1:0]    dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned MAX_DEPTH = (IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH;
  // Clear counter covers 0 .. MAX_DEPTH-1.
  localparam int unsigned CW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  // Pointer carries one extra bit so a run past the top of memory is visible
  // instead of silently wrapping to address 0.
  localparam int unsigned PW = CW + 1;

  localparam logic [CW-1:0]         C_LAST     = CW'(MAX_DEPTH - 1);
  localparam logic [CW:0]           IMEM_LIM_C = (CW + 1)'(IMEM_DEPTH);
  localparam logic [CW:0]           DMEM_LIM_C = (CW + 1)'(DMEM_DEPTH);
  localparam logic [PW-1:0]         IMEM_LIM_P = PW'(IMEM_DEPTH);
  localparam logic [PW-1:0]         DMEM_LIM_P = PW'(DMEM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] IMEM_LIM_W = DATA_WIDTH'(IMEM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] DMEM_LIM_W = DATA_WIDTH'(DMEM_DEPTH);

  typedef enum logic [2:0] {
    StClear,
    StHdr,
    StAddr,
    StData,
    StRun,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         c_q, c_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  tgt_q, tgt_d;       // 0: IMEM segment, 1: DMEM segment

  logic                  imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0]    imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
  logic                  dmem_we_q, dmem_we_d;
  logic [DMEM_AW-1:0]    dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
  logic                  core_rst_q, core_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  hs;
  logic [1:0]            hdr_op;
  logic [15:0]           hdr_cnt;
  logic                  c_in_imem;
  logic                  c_in_dmem;
  logic                  base_oob;
  logic                  ptr_oob;

  // reload masks the handshake in the cycle it is sampled.
  assign s_ready = ((state_q == StHdr) || (state_q == StAddr) || (state_q == StData)) &&
                   !reload;
  assign hs      = s_valid && s_ready;

  assign hdr_op  = s_data[31:30];
  assign hdr_cnt = s_data[15:0];

  assign c_in_imem = ({1'b0, c_q} < IMEM_LIM_C);
  assign c_in_dmem = ({1'b0, c_q} < DMEM_LIM_C);
  assign base_oob  = tgt_q ? (s_data >= DMEM_LIM_W) : (s_data >= IMEM_LIM_W);
  assign ptr_oob   = tgt_q ? (ptr_q >= DMEM_LIM_P) : (ptr_q >= IMEM_LIM_P);

  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    tgt_d        = tgt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    core_rst_d   = core_rst_q;
    done_d       = done_q;
    err_d        = err_q;

    if (reload) begin
      state_d    = StClear;
      c_d        = '0;
      core_rst_d = 1'b1;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          core_rst_d = 1'b1;
          if (c_in_imem) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = c_q[IMEM_AW-1:0];
            imem_wdata_d = '0;
          end
          if (c_in_dmem) begin
            dmem_we_d    = 1'b1;
            dmem_addr_d  = c_q[DMEM_AW-1:0];
            dmem_wdata_d = '0;
          end
          if (c_q == C_LAST) begin
            state_d = StHdr;
          end else begin
            c_d = c_q + 1'b1;
          end
        end

        StHdr: begin
          if (hs) begin
            unique case (hdr_op)
              2'b00, 2'b01: begin
                // A zero-length segment is consumed with no address phase.
                if (hdr_cnt != 16'd0) begin
                  tgt_d   = hdr_op[0];
                  cnt_d   = hdr_cnt;
                  state_d = StAddr;
                end
              end
              2'b10: begin
                state_d    = StRun;
                core_rst_d = 1'b0;
                done_d     = 1'b1;
              end
              default: begin
                state_d = StErr;
                err_d   = 1'b1;
              end
            endcase
          end
        end

        StAddr: begin
          if (hs) begin
            if (base_oob) begin
              state_d = StErr;
              err_d   = 1'b1;
            end else begin
              ptr_d   = s_data[PW-1:0];
              state_d = StData;
            end
          end
        end

        StData: begin
          if (hs) begin
            if (ptr_oob) begin
              // Segment ran off the end of memory: drop the word.
              state_d = StErr;
              err_d   = 1'b1;
            end else begin
              if (tgt_q) begin
                dmem_we_d    = 1'b1;
                dmem_addr_d  = ptr_q[DMEM_AW-1:0];
                dmem_wdata_d = s_data;
              end else begin
                imem_we_d    = 1'b1;
                imem_addr_d  = ptr_q[IMEM_AW-1:0];
                imem_wdata_d = s_data;
              end
              ptr_d = ptr_q + 1'b1;
              cnt_d = cnt_q - 1'b1;
              if (cnt_q == 16'd1) begin
                state_d = StHdr;
              end
            end
          end
        end

        StRun: begin
          core_rst_d = 1'b0;
          done_d     = 1'b1;
        end

        StErr: begin
          core_rst_d = 1'b1;
          err_d      = 1'b1;
        end

        default: begin
          state_d = StClear;
          c_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StClear;
      c_q          <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      tgt_q        <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Testbench for mips_boot_loader (IMEM_DEPTH=16, DMEM_DEPTH=1024).
// Expected memory writes are queued as stimulus is driven; a negedge monitor pops
// and compares every write strobe the DUT produces.

module tb_mips_boot_loader;

  localparam int unsigned IDEP = 16;
  localparam int unsigned DDEP = 1024;

  logic        clk;
  logic        rst;
  logic        reload;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  mips_boot_loader #(
    .DATA_WIDTH(32),
    .IMEM_DEPTH(IDEP),
    .DMEM_DEPTH(DDEP),
    .IMEM_AW   (4),
    .DMEM_AW   (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reload    (reload),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vec  = 0;
  int  miss = 0;

  // Scoreboard monitor: every observed write must match the oldest expectation.
  always @(negedge clk) begin
    if (imem_we) begin
      vec++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL imem_write_unexpected: got addr=%0d data=%h, required none", imem_addr,
                 imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.is_d !== 1'b0 || e.addr !== {6'd0, imem_addr} || e.data !== imem_wdata) begin
          miss++;
          $display("FAIL imem_write: got imem addr=%0d data=%h, required %s addr=%0d data=%h",
                   imem_addr, imem_wdata, e.is_d ? "dmem" : "imem", e.addr, e.data);
        end
      end
    end
    if (dmem_we) begin
      vec++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL dmem_write_unexpected: got addr=%0d data=%h, required none", dmem_addr,
                 dmem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.is_d !== 1'b1 || e.addr !== dmem_addr || e.data !== dmem_wdata) begin
          miss++;
          $display("FAIL dmem_write: got dmem addr=%0d data=%h, required %s addr=%0d data=%h",
                   dmem_addr, dmem_wdata, e.is_d ? "dmem" : "imem", e.addr, e.data);
        end
      end
    end
  end

  task automatic push_wr(input logic is_d, input int unsigned addr, input logic [31:0] data);
    wr_t e;
    e.is_d = is_d;
    e.addr = addr[9:0];
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    for (int c = 0; c < int'(DDEP); c++) begin
      if (c < int'(IDEP)) push_wr(1'b0, c, 32'd0);
      push_wr(1'b1, c, 32'd0);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [31:0] w, output int cyc);
    logic ok;
    logic fin;
    s_data  = w;
    s_valid = 1'b1;
    cyc     = 0;
    fin     = 1'b0;
    while (!fin) begin
      ok = s_ready;
      @(negedge clk);
      cyc++;
      if (ok) begin
        fin = 1'b1;
      end else if (cyc > 3000) begin
        vec++;
        miss++;
        $display("FAIL send_timeout: word %h not accepted after %0d cycles, required accept", w,
                 cyc);
        fin = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Counts negedges until s_ready is seen high (bounded).
  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!s_ready && cyc < 3000);
  endtask

  task automatic do_reload();
    int cyc;
    push_clear();
    s_valid = 1'b1;
    s_data  = 32'h4000_0001;
    reload  = 1'b1;
    #1;
    vec++;
    if (s_ready !== 1'b0) begin
      miss++;
      $display("FAIL reload_ready_mask: s_ready=%b, required 0", s_ready);
    end
    @(negedge clk);
    reload  = 1'b0;
    s_valid = 1'b0;
    vec++;
    if (core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      miss++;
      $display("FAIL reload_flags: core_rst=%b done=%b err=%b, required 1 0 0", core_rst, done,
               err);
    end
    wait_ready(cyc);
    vec++;
    if (cyc != int'(DDEP)) begin
      miss++;
      $display("FAIL reload_clear_len: %0d cycles to ready, required %0d", cyc, DDEP);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    reload  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    @(negedge clk);
    @(negedge clk);
    vec++;
    if (s_ready !== 1'b0 || imem_we !== 1'b0 || dmem_we !== 1'b0) begin
      miss++;
      $display("FAIL reset_strobes: s_ready=%b imem_we=%b dmem_we=%b, required 0 0 0", s_ready,
               imem_we, dmem_we);
    end
    vec++;
    if (imem_addr !== 4'd0 || imem_wdata !== 32'd0 || dmem_addr !== 10'd0 ||
        dmem_wdata !== 32'd0) begin
      miss++;
      $display("FAIL reset_bus: ia=%0d iw=%h da=%0d dw=%h, required all 0", imem_addr,
               imem_wdata, dmem_addr, dmem_wdata);
    end
    vec++;
    if (core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      miss++;
      $display("FAIL reset_flags: core_rst=%b done=%b err=%b, required 1 0 0", core_rst, done,
               err);
    end
  endtask

  task automatic test_clear();
    int cyc;
    push_clear();
    rst = 1'b1;
    wait_ready(cyc);
    vec++;
    if (cyc != int'(DDEP)) begin
      miss++;
      $display("FAIL clear_len: %0d cycles to ready, required %0d", cyc, DDEP);
    end
    vec++;
    if (core_rst !== 1'b1 || done !== 1'b0) begin
      miss++;
      $display("FAIL clear_core_rst: core_rst=%b done=%b, required 1 0", core_rst, done);
    end
  endtask

  task automatic test_program_load();
    logic [31:0] prog[15];
    int cyc;
    prog = '{32'h0000_0000, 32'h0000_0820, 32'h2002_0024, 32'h2003_0001, 32'h0043_2020,
             32'hAC04_0000, 32'h8C05_0000, 32'h10A0_0002, 32'h2063_FFFF, 32'h0000_0000,
             32'h1460_FFFB, 32'h0000_0000, 32'h0000_0000, 32'h0810_000C, 32'h0000_0000};
    send(32'h0000_000F, cyc);
    send(32'd0, cyc);
    for (int i = 0; i < 15; i++) begin
      push_wr(1'b0, i, prog[i]);
      send(prog[i], cyc);
    end
    send(32'h4000_000D, cyc);
    send(32'd0, cyc);
    for (int i = 0; i < 13; i++) begin
      logic [31:0] v;
      v = (i < 10) ? 32'(10 - i) : 32'd0;
      push_wr(1'b1, i, v);
      send(v, cyc);
    end
    vec++;
    if (core_rst !== 1'b1 || done !== 1'b0) begin
      miss++;
      $display("FAIL pre_go: core_rst=%b done=%b, required 1 0", core_rst, done);
    end
    send(32'h8000_0000, cyc);
    s_valid = 1'b0;
    vec++;
    if (core_rst !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin
      miss++;
      $display("FAIL go: core_rst=%b done=%b err=%b, required 0 1 0", core_rst, done, err);
    end
    #1;
    vec++;
    if (s_ready !== 1'b0) begin
      miss++;
      $display("FAIL run_ready: s_ready=%b, required 0", s_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reload_run();
    do_reload();
  endtask

  task automatic test_zero_count_and_gaps();
    int cyc;
    send(32'h0000_0000, cyc);
    idle(1);
    vec++;
    if (s_ready !== 1'b1 || err !== 1'b0) begin
      miss++;
      $display("FAIL zero_count: s_ready=%b err=%b, required 1 0", s_ready, err);
    end
    // If the zero-count header had opened an address phase, the header below would be
    // taken as a base and the write addresses would miss.
    send(32'h4000_0004, cyc);
    idle($urandom_range(0, 3));
    send(32'd1020, cyc);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 4));
      push_wr(1'b1, 1020 + i, 32'hD000_0000 + 32'(i));
      send(32'hD000_0000 + 32'(i), cyc);
    end
    idle(3);
    vec++;
    if (err !== 1'b0 || s_ready !== 1'b1) begin
      miss++;
      $display("FAIL gaps_end: err=%b s_ready=%b, required 0 1", err, s_ready);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int tot;
    tot = 0;
    send(32'h0000_0002, cyc); tot += cyc;
    send(32'd3, cyc);         tot += cyc;
    push_wr(1'b0, 3, 32'hB2B0_0001);
    send(32'hB2B0_0001, cyc); tot += cyc;
    push_wr(1'b0, 4, 32'hB2B0_0002);
    send(32'hB2B0_0002, cyc); tot += cyc;
    send(32'h4000_0001, cyc); tot += cyc;
    send(32'd7, cyc);         tot += cyc;
    push_wr(1'b1, 7, 32'hB2B0_0003);
    send(32'hB2B0_0003, cyc); tot += cyc;
    idle(1);
    vec++;
    if (tot != 7) begin
      miss++;
      $display("FAIL back_to_back: %0d cycles for 7 words, required 7", tot);
    end
  endtask

  task automatic test_reload_mid_data();
    int cyc;
    send(32'h0000_0005, cyc);
    send(32'd2, cyc);
    push_wr(1'b0, 2, 32'hAAAA_0002);
    send(32'hAAAA_0002, cyc);
    push_wr(1'b0, 3, 32'hAAAA_0003);
    send(32'hAAAA_0003, cyc);
    do_reload();
  endtask

  task automatic test_range_base();
    int cyc;
    send(32'h0000_0002, cyc);
    send(32'd16, cyc);
    s_valid = 1'b0;
    vec++;
    if (err !== 1'b1 || core_rst !== 1'b1) begin
      miss++;
      $display("FAIL base_oob: err=%b core_rst=%b, required 1 1", err, core_rst);
    end
    #1;
    vec++;
    if (s_ready !== 1'b0) begin
      miss++;
      $display("FAIL err_ready: s_ready=%b, required 0", s_ready);
    end
    @(negedge clk);
    do_reload();
  endtask

  task automatic test_range_wrap();
    int cyc;
    send(32'h0000_0003, cyc);
    send(32'd14, cyc);
    push_wr(1'b0, 14, 32'hCAFE_000E);
    send(32'hCAFE_000E, cyc);
    push_wr(1'b0, 15, 32'hCAFE_000F);
    send(32'hCAFE_000F, cyc);
    vec++;
    if (err !== 1'b0) begin
      miss++;
      $display("FAIL wrap_early_err: err=%b, required 0", err);
    end
    send(32'hCAFE_0010, cyc);
    s_valid = 1'b0;
    vec++;
    if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin
      miss++;
      $display("FAIL wrap_err: err=%b core_rst=%b done=%b, required 1 1 0", err, core_rst, done);
    end
    idle(3);
    vec++;
    if (err !== 1'b1 || core_rst !== 1'b1) begin
      miss++;
      $display("FAIL err_sticky: err=%b core_rst=%b, required 1 1", err, core_rst);
    end
    do_reload();
  endtask

  task automatic test_illegal_op();
    int cyc;
    send(32'hC000_0001, cyc);
    s_valid = 1'b0;
    vec++;
    if (err !== 1'b1 || core_rst !== 1'b1) begin
      miss++;
      $display("FAIL illegal_op: err=%b core_rst=%b, required 1 1", err, core_rst);
    end
    do_reload();
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    send(32'h0000_0004, cyc);
    send(32'd0, cyc);
    push_wr(1'b0, 0, 32'h1111_0000);
    send(32'h1111_0000, cyc);
    push_wr(1'b0, 1, 32'h1111_0001);
    send(32'h1111_0001, cyc);
    s_data = 32'h1111_0002;
    #2;
    rst = 1'b0;
    #1;
    vec++;
    if (imem_we !== 1'b0 || dmem_we !== 1'b0 || imem_addr !== 4'd0 || imem_wdata !== 32'd0 ||
        s_ready !== 1'b0) begin
      miss++;
      $display("FAIL rst_mid_load: we=%b/%b ia=%0d iw=%h rdy=%b, required all 0", imem_we,
               dmem_we, imem_addr, imem_wdata, s_ready);
    end
    vec++;
    if (core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      miss++;
      $display("FAIL rst_mid_flags: core_rst=%b done=%b err=%b, required 1 0 0", core_rst,
               done, err);
    end
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push_clear();
    rst = 1'b1;
    wait_ready(cyc);
    vec++;
    if (cyc != int'(DDEP)) begin
      miss++;
      $display("FAIL rst_clear_len: %0d cycles to ready, required %0d", cyc, DDEP);
    end
  endtask

  initial begin
    rst     = 1'b0;
    reload  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    @(negedge clk);
    test_reset();
    test_clear();
    test_program_load();
    test_reload_run();
    test_zero_count_and_gaps();
    test_back_to_back();
    test_reload_mid_data();
    test_range_base();
    test_range_wrap();
    test_illegal_op();
    test_reset_mid_load();
    idle(5);
    vec++;
    if (exp_q.size() != 0) begin
      miss++;
      $display("FAIL pending_writes: %0d expected writes never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
